// File: rtl/encoding_block.sv
// Transmit-side block encoder: packs one byte per lane per cycle into a
// 64b/66b (Gen2), 128b/132b (Gen3) or 16-byte (Gen4) block per lane.
// Optional macro ENC_BLOCK_CNT_EN adds a 16-bit wrapping count of emitted blocks.
module encoding_block #(
  parameter logic [3:0] GEN3_SYNC_DATA = 4'b1010,
  parameter logic [3:0] GEN3_SYNC_OS   = 4'b0101,
  parameter logic [1:0] GEN2_SYNC_DATA = 2'b10,
  parameter logic [1:0] GEN2_SYNC_OS   = 2'b01
) (
  input  logic         enc_clk,
  input  logic         rst,
  input  logic         enable_enc,
  input  logic [1:0]   gen_speed,
  input  logic         data_os,
  input  logic [7:0]   lane_0_tx,
  input  logic [7:0]   lane_1_tx,
  output logic [131:0] lane_0_tx_enc,
  output logic [131:0] lane_1_tx_enc,
  output logic         enc_valid
`ifdef ENC_BLOCK_CNT_EN
  ,
  output logic [15:0]  blocks_sent
`endif
);

  localparam logic [1:0] SpeedGen4 = 2'b00;
  localparam logic [1:0] SpeedGen3 = 2'b01;
  localparam logic [1:0] SpeedGen2 = 2'b10;
  localparam logic [1:0] SpeedRsvd = 2'b11;

  logic [3:0]   cnt_q, cnt_d;
  logic [1:0]   speed_q, speed_d;
  logic         dos_q, dos_d;
  logic [127:0] stage0_q, stage0_d, stage1_q, stage1_d;
  // Completed blocks wait here one cycle so the next block can start at once
  logic [131:0] blk0_q, blk0_d, blk1_q, blk1_d;
  logic         pend_q, pend_d;

  logic [1:0]   speed_eff;
  logic         dos_eff;
  logic         last_byte;

  function automatic logic [131:0] pack(input logic [127:0] p, input logic [1:0] spd,
                                        input logic dos);
    logic [131:0] w;
    case (spd)
      SpeedGen3: w = {p, (dos ? GEN3_SYNC_DATA : GEN3_SYNC_OS)};
      SpeedGen2: w = {66'b0, p[63:0], (dos ? GEN2_SYNC_DATA : GEN2_SYNC_OS)};
      default:   w = {4'b0, p};
    endcase
    return w;
  endfunction

  // Next-state: byte acceptance, control latching on byte 0, block completion
  always_comb begin
    cnt_d    = cnt_q;
    speed_d  = speed_q;
    dos_d    = dos_q;
    stage0_d = stage0_q;
    stage1_d = stage1_q;
    blk0_d   = blk0_q;
    blk1_d   = blk1_q;
    pend_d   = 1'b0;

    // Controls come straight from the inputs on byte 0, from the latch afterwards
    speed_eff = (cnt_q == 4'd0) ? gen_speed : speed_q;
    dos_eff   = (cnt_q == 4'd0) ? data_os   : dos_q;
    last_byte = (speed_eff == SpeedGen2) ? (cnt_q == 4'd7) : (cnt_q == 4'd15);

    if (!enable_enc) begin
      cnt_d    = 4'd0;
      stage0_d = '0;
      stage1_d = '0;
    end else if (speed_eff != SpeedRsvd) begin
      if (cnt_q == 4'd0) begin
        speed_d = gen_speed;
        dos_d   = data_os;
      end
      stage0_d[{cnt_q, 3'b000} +: 8] = lane_0_tx;
      stage1_d[{cnt_q, 3'b000} +: 8] = lane_1_tx;
      if (last_byte) begin
        cnt_d  = 4'd0;
        pend_d = 1'b1;
        blk0_d = pack(stage0_d, speed_eff, dos_eff);
        blk1_d = pack(stage1_d, speed_eff, dos_eff);
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge enc_clk) begin
    if (rst) begin
      cnt_q    <= 4'd0;
      speed_q  <= SpeedGen4;
      dos_q    <= 1'b0;
      stage0_q <= '0;
      stage1_q <= '0;
      blk0_q   <= '0;
      blk1_q   <= '0;
      pend_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      speed_q  <= speed_d;
      dos_q    <= dos_d;
      stage0_q <= stage0_d;
      stage1_q <= stage1_d;
      blk0_q   <= blk0_d;
      blk1_q   <= blk1_d;
      pend_q   <= pend_d;
    end
  end

  // Output stage: publish a completed block with a one-cycle strobe, else hold
  always_ff @(posedge enc_clk) begin
    if (rst) begin
      lane_0_tx_enc <= '0;
      lane_1_tx_enc <= '0;
      enc_valid     <= 1'b0;
    end else begin
      enc_valid <= pend_q;
      if (pend_q) begin
        lane_0_tx_enc <= blk0_q;
        lane_1_tx_enc <= blk1_q;
      end
    end
  end

`ifdef ENC_BLOCK_CNT_EN
  // Emitted-block counter, steps on the same edge enc_valid rises
  always_ff @(posedge enc_clk) begin
    if (rst) begin
      blocks_sent <= 16'd0;
    end else if (pend_q) begin
      blocks_sent <= blocks_sent + 16'd1;
    end
  end
`endif

endmodule
